// File: rtl/cpu_boot_loader_pkg.sv
// Shared definitions for the CPU boot loader: FSM state encoding,
// default memory map / run-length constants and the address helper.
package cpu_boot_defs;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR     = 3'd1,
    ST_LOAD    = 3'd2,
    ST_RELEASE = 3'd3,
    ST_RUN     = 3'd4,
    ST_HALT    = 3'd5,
    ST_ERR     = 3'd6
  } boot_state_t;

  localparam logic [31:0] DEFAULT_TEXT_BASE  = 32'h0000_3000;
  localparam int          DEFAULT_IMEM_DEPTH = 1024;
  localparam int          DEFAULT_RUN_CYCLES = 40;

  // Byte address of instruction word 'index' relative to 'base'; wraps at 32 bits.
  function automatic logic [31:0] word_byte_addr(input logic [31:0] base,
                                                 input logic [31:0] index);
    return base + (index << 2);
  endfunction

endpackage

// File: rtl/cpu_boot_loader_word_packer.sv
// Assembles an MSB-first byte stream into 32-bit words. The completed word
// and its valid strobe are presented combinationally in the same cycle as the
// fourth byte, so the caller can register them directly into its outputs.
module word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [23:0] shift_q;
  logic [1:0]  count_q;

  // Shift accepted bytes in from the right and count them; clear drops a partial word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q <= '0;
      count_q <= '0;
    end else if (clear) begin
      shift_q <= '0;
      count_q <= '0;
    end else if (byte_en) begin
      shift_q <= {shift_q[15:0], byte_in};
      count_q <= count_q + 2'd1;
    end
  end

  assign word       = {shift_q, byte_in};
  assign word_valid = byte_en && (count_q == 2'd3);

endmodule

// File: rtl/cpu_boot_loader.sv
// Boot loader for the single-cycle CPU. Receives a word count and that many
// instruction words over a byte stream, writes them to instruction memory
// starting at TEXT_BASE with the CPU held in reset, then releases the CPU for
// exactly RUN_CYCLES enabled clocks and freezes it for inspection.
import cpu_boot_defs::*;

module cpu_boot_loader #(
  parameter logic [31:0] TEXT_BASE  = DEFAULT_TEXT_BASE,
  parameter int          IMEM_DEPTH = DEFAULT_IMEM_DEPTH,
  parameter int          RUN_CYCLES = DEFAULT_RUN_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_rst,
  output logic        cpu_clk_en,
  output logic        busy,
  output logic        run_done,
  output logic        err,
  output logic [31:0] cycles
);

  localparam logic [31:0] DEPTH_LIMIT = 32'(IMEM_DEPTH);
  localparam logic [31:0] RUN_LAST    = 32'(RUN_CYCLES - 1);

  boot_state_t state, next_state;

  logic [31:0] n_words;
  logic [31:0] index;
  logic [31:0] word;
  logic        word_valid;
  logic        byte_en;
  logic        last_word;
  logic        packer_clear;

  logic in_ready_d;
  logic imem_we_d;
  logic cpu_rst_d;
  logic cpu_clk_en_d;
  logic busy_d;
  logic run_done_d;
  logic err_d;

  assign byte_en      = in_valid && in_ready;
  assign last_word    = (index == n_words - 32'd1);
  assign packer_clear = (next_state == ST_HDR) && (state != ST_HDR);

  word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (packer_clear),
    .byte_en    (byte_en),
    .byte_in    (in_data),
    .word       (word),
    .word_valid (word_valid)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode: header check, end-of-load detection and run-length limit.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (start) next_state = ST_HDR;
      end
      ST_HDR: begin
        if (word_valid) begin
          if (word == 32'd0)            next_state = ST_RELEASE;
          else if (word > DEPTH_LIMIT)  next_state = ST_ERR;
          else                          next_state = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (imem_we && last_word) next_state = ST_RELEASE;
      end
      ST_RELEASE: begin
        next_state = ST_RUN;
      end
      ST_RUN: begin
        if (cycles == RUN_LAST) next_state = ST_HALT;
      end
      ST_HALT, ST_ERR: begin
        if (start) next_state = ST_HDR;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state; the last word's write cycle stops taking bytes.
  always_comb begin
    in_ready_d   = (next_state == ST_HDR) ||
                   ((next_state == ST_LOAD) && !((state == ST_LOAD) && word_valid && last_word));
    imem_we_d    = (state == ST_LOAD) && word_valid;
    cpu_rst_d    = !((next_state == ST_RUN) || (next_state == ST_HALT));
    cpu_clk_en_d = (next_state == ST_RUN);
    busy_d       = (next_state == ST_HDR) || (next_state == ST_LOAD) ||
                   (next_state == ST_RELEASE) || (next_state == ST_RUN);
    run_done_d   = (next_state == ST_HALT);
    err_d        = (next_state == ST_ERR);
  end

  // Output registers; address and data only change when a word is written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= TEXT_BASE;
      imem_wdata <= '0;
      cpu_rst    <= 1'b1;
      cpu_clk_en <= 1'b0;
      busy       <= 1'b0;
      run_done   <= 1'b0;
      err        <= 1'b0;
    end else begin
      in_ready   <= in_ready_d;
      imem_we    <= imem_we_d;
      cpu_rst    <= cpu_rst_d;
      cpu_clk_en <= cpu_clk_en_d;
      busy       <= busy_d;
      run_done   <= run_done_d;
      err        <= err_d;
      if (imem_we_d) begin
        imem_addr  <= word_byte_addr(TEXT_BASE, index);
        imem_wdata <= word;
      end
    end
  end

  // Word count latch and write index, advanced once per completed write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_words <= '0;
      index   <= '0;
    end else if ((state == ST_HDR) && word_valid) begin
      n_words <= word;
      index   <= '0;
    end else if (imem_we) begin
      index <= index + 32'd1;
    end
  end

  // CPU cycle counter: counts every RUN clock, holds in HALT, clears on a new load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycles <= '0;
    end else if (state == ST_RUN) begin
      cycles <= cycles + 32'd1;
    end else if (packer_clear) begin
      cycles <= '0;
    end
  end

endmodule

// File: tb/tb_cpu_boot_loader.sv
// Directed testbench for cpu_boot_loader: reset values, a two-word load,
// run length, empty and oversized headers, gapped input and mid-load reset.
module tb_cpu_boot_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_rst;
  logic        cpu_clk_en;
  logic        busy;
  logic        run_done;
  logic        err;
  logic [31:0] cycles;

  int errors = 0;
  int checks = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int en_count  = 0;
  int acc_count = 0;
  int wr_base   = 0;
  int en_base   = 0;
  int acc_base  = 0;

  cpu_boot_loader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rst    (cpu_rst),
    .cpu_clk_en (cpu_clk_en),
    .busy       (busy),
    .run_done   (run_done),
    .err        (err),
    .cycles     (cycles)
  );

  // 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Observe writes, enabled CPU clocks and accepted bytes mid-cycle.
  always @(negedge clk) begin
    if (imem_we) begin
      wr_addr_q.push_back(imem_addr);
      wr_data_q.push_back(imem_wdata);
    end
    if (cpu_clk_en) en_count++;
    if (in_valid && in_ready) acc_count++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_marks();
    wr_base  = wr_addr_q.size();
    en_base  = en_count;
    acc_base = acc_count;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ready;
    int t;
    t = 0;
    ready = 1'b0;
    in_data  = b;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      ready = in_ready;
      tick();
      t++;
    end while (!ready && t < 64);
    in_valid = 1'b0;
    checks++;
    if (!ready) begin
      errors++;
      $display("[TB] FAIL send_byte_timeout: byte %02h not accepted, in_ready=%0b required 1", b, in_ready);
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
  endtask

  task automatic wait_run_done();
    int t;
    t = 0;
    while (!run_done && t < 200) begin
      tick();
      t++;
    end
    checks++;
    if (!run_done) begin
      errors++;
      $display("[TB] FAIL run_done_timeout: run_done=%0b required 1", run_done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    #1 rst = 1'b0;
    #18;
    checks++; if (in_ready !== 1'b0)          begin errors++; $display("[TB] FAIL reset_in_ready: got %0b exp 0", in_ready); end
    checks++; if (imem_we !== 1'b0)           begin errors++; $display("[TB] FAIL reset_imem_we: got %0b exp 0", imem_we); end
    checks++; if (imem_addr !== 32'h3000)     begin errors++; $display("[TB] FAIL reset_imem_addr: got %08h exp 00003000", imem_addr); end
    checks++; if (imem_wdata !== 32'h0)       begin errors++; $display("[TB] FAIL reset_imem_wdata: got %08h exp 0", imem_wdata); end
    checks++; if (cpu_rst !== 1'b1)           begin errors++; $display("[TB] FAIL reset_cpu_rst: got %0b exp 1", cpu_rst); end
    checks++; if (cpu_clk_en !== 1'b0)        begin errors++; $display("[TB] FAIL reset_cpu_clk_en: got %0b exp 0", cpu_clk_en); end
    checks++; if ({busy, run_done, err} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags: got busy/done/err=%03b exp 000", {busy, run_done, err}); end
    checks++; if (cycles !== 32'd0)           begin errors++; $display("[TB] FAIL reset_cycles: got %0d exp 0", cycles); end
    rst = 1'b1;
    in_valid = 1'b1; in_data = 8'h5A;
    tick(); tick();
    checks++; if (in_ready !== 1'b0)          begin errors++; $display("[TB] FAIL idle_in_ready: got %0b exp 0", in_ready); end
    in_valid = 1'b0;
  endtask

  task automatic test_load_two();
    set_marks();
    pulse_start();
    checks++; if ({in_ready, busy, cpu_rst} !== 3'b111) begin errors++; $display("[TB] FAIL hdr_outputs: got ready/busy/cpu_rst=%03b exp 111", {in_ready, busy, cpu_rst}); end
    send_word(32'd2);
    send_word(32'h2001_0005);
    send_word(32'h0000_0000);
    checks++; if (imem_we !== 1'b1)       begin errors++; $display("[TB] FAIL last_write_we: got %0b exp 1", imem_we); end
    checks++; if (imem_addr !== 32'h3004) begin errors++; $display("[TB] FAIL last_write_addr: got %08h exp 00003004", imem_addr); end
    checks++; if (in_ready !== 1'b0)      begin errors++; $display("[TB] FAIL last_write_in_ready: got %0b exp 0", in_ready); end
    tick();
    checks++; if ({imem_we, cpu_rst, cpu_clk_en, busy} !== 4'b0101) begin errors++; $display("[TB] FAIL release_cycle: got we/rst/en/busy=%04b exp 0101", {imem_we, cpu_rst, cpu_clk_en, busy}); end
    tick();
    checks++; if ({cpu_rst, cpu_clk_en} !== 2'b01) begin errors++; $display("[TB] FAIL run_entry: got rst/en=%02b exp 01", {cpu_rst, cpu_clk_en}); end
    checks++; if (cycles !== 32'd0)       begin errors++; $display("[TB] FAIL run_entry_cycles: got %0d exp 0", cycles); end
    checks++;
    if (wr_addr_q.size() - wr_base != 2) begin
      errors++; $display("[TB] FAIL load2_write_count: got %0d exp 2", wr_addr_q.size() - wr_base);
    end else begin
      if (wr_addr_q[wr_base] !== 32'h3000 || wr_data_q[wr_base] !== 32'h2001_0005) begin
        errors++; $display("[TB] FAIL load2_write0: got (%08h,%08h) exp (00003000,20010005)", wr_addr_q[wr_base], wr_data_q[wr_base]);
      end
      checks++;
      if (wr_addr_q[wr_base+1] !== 32'h3004 || wr_data_q[wr_base+1] !== 32'h0) begin
        errors++; $display("[TB] FAIL load2_write1: got (%08h,%08h) exp (00003004,00000000)", wr_addr_q[wr_base+1], wr_data_q[wr_base+1]);
      end
    end
  endtask

  task automatic test_run_length();
    wait_run_done();
    checks++; if (en_count - en_base != 40) begin errors++; $display("[TB] FAIL run_enabled_cycles: got %0d exp 40", en_count - en_base); end
    checks++; if (cycles !== 32'd40)        begin errors++; $display("[TB] FAIL halt_cycles: got %0d exp 40", cycles); end
    checks++; if ({run_done, cpu_rst, cpu_clk_en, busy} !== 4'b1000) begin errors++; $display("[TB] FAIL halt_outputs: got done/rst/en/busy=%04b exp 1000", {run_done, cpu_rst, cpu_clk_en, busy}); end
    tick(); tick(); tick();
    checks++; if (cycles !== 32'd40)        begin errors++; $display("[TB] FAIL halt_cycles_hold: got %0d exp 40", cycles); end
  endtask

  task automatic test_zero_and_overflow();
    set_marks();
    pulse_start();
    checks++; if ({cycles, run_done, cpu_rst} !== {32'd0, 1'b0, 1'b1}) begin errors++; $display("[TB] FAIL restart_clears: got cycles=%0d done=%0b rst=%0b exp 0/0/1", cycles, run_done, cpu_rst); end
    send_word(32'd0);
    checks++; if ({busy, in_ready, cpu_clk_en, cpu_rst, imem_we} !== 5'b10010) begin errors++; $display("[TB] FAIL zero_release: got busy/ready/en/rst/we=%05b exp 10010", {busy, in_ready, cpu_clk_en, cpu_rst, imem_we}); end
    tick();
    checks++; if (cpu_clk_en !== 1'b1) begin errors++; $display("[TB] FAIL zero_run: got en=%0b exp 1", cpu_clk_en); end
    wait_run_done();
    checks++; if (wr_addr_q.size() != wr_base) begin errors++; $display("[TB] FAIL zero_no_write: got %0d writes exp 0", wr_addr_q.size() - wr_base); end

    set_marks();
    pulse_start();
    send_word(32'd1025);
    checks++; if ({err, in_ready, cpu_rst, busy} !== 4'b1010) begin errors++; $display("[TB] FAIL overflow_err: got err/ready/rst/busy=%04b exp 1010", {err, in_ready, cpu_rst, busy}); end
    in_valid = 1'b1; in_data = 8'h77;
    tick(); tick(); tick();
    in_valid = 1'b0;
    checks++; if (acc_count - acc_base != 4) begin errors++; $display("[TB] FAIL overflow_bytes_taken: got %0d exp 4", acc_count - acc_base); end
    checks++; if (wr_addr_q.size() != wr_base) begin errors++; $display("[TB] FAIL overflow_no_write: got %0d writes exp 0", wr_addr_q.size() - wr_base); end
  endtask

  task automatic test_gapped_stream();
    logic [7:0] stream [12];
    int gap;
    stream = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
    set_marks();
    pulse_start();
    checks++; if ({err, in_ready} !== 2'b01) begin errors++; $display("[TB] FAIL err_restart: got err/ready=%02b exp 01", {err, in_ready}); end
    for (int i = 0; i < 12; i++) begin
      send_byte(stream[i]);
      gap = (i == 5) ? 2 : int'($urandom_range(0, 2));
      if (i == 11) gap = 0;
      repeat (gap) tick();
    end
    wait_run_done();
    checks++; if (acc_count - acc_base != 12) begin errors++; $display("[TB] FAIL gap_bytes_taken: got %0d exp 12", acc_count - acc_base); end
    checks++; if (en_count - en_base != 40)   begin errors++; $display("[TB] FAIL gap_enabled_cycles: got %0d exp 40", en_count - en_base); end
    checks++;
    if (wr_addr_q.size() - wr_base != 2) begin
      errors++; $display("[TB] FAIL gap_write_count: got %0d exp 2", wr_addr_q.size() - wr_base);
    end else begin
      if (wr_addr_q[wr_base] !== 32'h3000 || wr_data_q[wr_base] !== 32'h2001_0005) begin
        errors++; $display("[TB] FAIL gap_write0: got (%08h,%08h) exp (00003000,20010005)", wr_addr_q[wr_base], wr_data_q[wr_base]);
      end
      checks++;
      if (wr_addr_q[wr_base+1] !== 32'h3004 || wr_data_q[wr_base+1] !== 32'h0) begin
        errors++; $display("[TB] FAIL gap_write1: got (%08h,%08h) exp (00003004,00000000)", wr_addr_q[wr_base+1], wr_data_q[wr_base+1]);
      end
    end
  endtask

  task automatic test_reset_mid_load();
    set_marks();
    pulse_start();
    send_word(32'd2);
    send_word(32'h1122_3344);
    send_byte(8'h55);
    send_byte(8'h66);
    rst = 1'b0;
    #2;
    checks++; if ({in_ready, imem_we, cpu_rst, busy, cpu_clk_en} !== 5'b00100) begin errors++; $display("[TB] FAIL midreset_ctrl: got ready/we/rst/busy/en=%05b exp 00100", {in_ready, imem_we, cpu_rst, busy, cpu_clk_en}); end
    checks++; if ({imem_addr, imem_wdata} !== {32'h3000, 32'h0}) begin errors++; $display("[TB] FAIL midreset_imem: got (%08h,%08h) exp (00003000,00000000)", imem_addr, imem_wdata); end
    checks++; if (wr_addr_q.size() - wr_base != 1) begin errors++; $display("[TB] FAIL midreset_prior_writes: got %0d exp 1", wr_addr_q.size() - wr_base); end
    @(negedge clk);
    rst = 1'b1;
    tick();

    set_marks();
    pulse_start();
    send_word(32'd1);
    send_word(32'hAABB_CCDD);
    tick();
    tick();
    checks++;
    if (wr_addr_q.size() - wr_base != 1) begin
      errors++; $display("[TB] FAIL reload_write_count: got %0d exp 1", wr_addr_q.size() - wr_base);
    end else if (wr_addr_q[wr_base] !== 32'h3000 || wr_data_q[wr_base] !== 32'hAABB_CCDD) begin
      errors++; $display("[TB] FAIL reload_write: got (%08h,%08h) exp (00003000,AABBCCDD)", wr_addr_q[wr_base], wr_data_q[wr_base]);
    end
    pulse_start();
    checks++; if ({busy, cpu_clk_en, cpu_rst, in_ready} !== 4'b1100) begin errors++; $display("[TB] FAIL start_in_run: got busy/en/rst/ready=%04b exp 1100", {busy, cpu_clk_en, cpu_rst, in_ready}); end
    checks++; if (cycles !== 32'd1) begin errors++; $display("[TB] FAIL start_in_run_cycles: got %0d exp 1", cycles); end
    in_valid = 1'b1; in_data = 8'hFF;
    tick(); tick(); tick();
    in_valid = 1'b0;
    checks++; if (acc_count - acc_base != 8) begin errors++; $display("[TB] FAIL run_bytes_taken: got %0d exp 8", acc_count - acc_base); end
    wait_run_done();
    checks++; if (en_count - en_base != 40) begin errors++; $display("[TB] FAIL reload_enabled_cycles: got %0d exp 40", en_count - en_base); end
    checks++; if (wr_addr_q.size() - wr_base != 1) begin errors++; $display("[TB] FAIL reload_final_writes: got %0d exp 1", wr_addr_q.size() - wr_base); end
  endtask

  initial begin
    test_reset();
    test_load_two();
    test_run_length();
    test_zero_and_overflow();
    test_gapped_stream();
    test_reset_mid_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
